// File: rtl/obi_accel_ctrl_regs.sv
// OBI control/status register block serving NumChannels edge-detection engines.
// Zero-wait-state grant, registered one-cycle responses, sticky done flags, maskable level IRQ.
module obi_accel_ctrl_regs #(
    parameter int unsigned NumChannels = 2,
    parameter logic [31:0] BaseAddr    = 32'h2000_0000,
    parameter int unsigned DimWidth    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            obi_req_i,
    output logic                            obi_gnt_o,
    input  logic [31:0]                     obi_addr_i,
    input  logic                            obi_we_i,
    input  logic [3:0]                      obi_be_i,
    input  logic [31:0]                     obi_wdata_i,
    output logic                            obi_rvalid_o,
    output logic [31:0]                     obi_rdata_o,
    output logic                            obi_err_o,
    output logic [NumChannels-1:0]          start_o,
    output logic [NumChannels-1:0]          clear_o,
    input  logic [NumChannels-1:0]          done_i,
    output logic [NumChannels-1:0]          busy_o,
    output logic [NumChannels*32-1:0]       base_addr_o,
    output logic [NumChannels*DimWidth-1:0] width_o,
    output logic [NumChannels*DimWidth-1:0] height_o,
    output logic                            irq_o
);

    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    localparam logic [2:0] CREG_CTRL     = 3'd0;
    localparam logic [2:0] CREG_STATUS   = 3'd1;
    localparam logic [2:0] CREG_BASE     = 3'd2;
    localparam logic [2:0] CREG_WIDTH    = 3'd3;
    localparam logic [2:0] CREG_HEIGHT   = 3'd4;
    localparam logic [2:0] GREG_IRQ_EN   = 3'd0;
    localparam logic [2:0] GREG_IRQ_PEND = 3'd1;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode: the crossbar has already selected this block, upper bits are don't-care.
    logic [11:0]            offset;
    logic [6:0]             slot;
    logic [2:0]             reg_idx;
    logic [ChW-1:0]         ch_idx;
    logic [NumChannels-1:0] ch_sel;
    logic                   unused_bits;

    assign offset      = obi_addr_i[11:0];
    assign slot        = offset[11:5];
    assign reg_idx     = offset[4:2];
    assign ch_idx      = slot[ChW-1:0];
    assign ch_sel      = NumChannels'(1) << ch_idx;
    assign unused_bits = ^{obi_addr_i[31:12], BaseAddr};

    logic                   rvalid_q, err_q;
    logic [31:0]            rdata_q;
    logic [NumChannels-1:0] start_q, start_d, clear_q, clear_d;
    logic [NumChannels-1:0] busy_q, busy_d, done_q, done_d;
    logic [NumChannels-1:0] irq_en_q, irq_en_d;
    logic                   irq_q;
    logic [31:0]            base_q   [NumChannels];
    logic [31:0]            base_d   [NumChannels];
    logic [DimWidth-1:0]    width_q  [NumChannels];
    logic [DimWidth-1:0]    width_d  [NumChannels];
    logic [DimWidth-1:0]    height_q [NumChannels];
    logic [DimWidth-1:0]    height_d [NumChannels];

    logic                   acc_err;
    logic [31:0]            acc_rdata;
    logic [NumChannels-1:0] wr_start, wr_clear, wr_w1c, wr_base, wr_width, wr_height;
    logic                   wr_irq_en;

    // NOTE: every output of a combinational block gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        acc_err   = 1'b0;
        acc_rdata = '0;
        wr_start  = '0;
        wr_clear  = '0;
        wr_w1c    = '0;
        wr_base   = '0;
        wr_width  = '0;
        wr_height = '0;
        wr_irq_en = 1'b0;
        if (obi_req_i) begin
            if (offset[1:0] != 2'b00 || slot > 7'(NumChannels)) begin
                acc_err = 1'b1;
            end else if (slot == 7'(NumChannels)) begin
                case (reg_idx)
                    GREG_IRQ_EN: begin
                        if (obi_we_i) wr_irq_en = 1'b1;
                        else          acc_rdata = 32'(irq_en_q);
                    end
                    GREG_IRQ_PEND: begin
                        if (obi_we_i) acc_err   = 1'b1;
                        else          acc_rdata = 32'(done_q & irq_en_q);
                    end
                    default: acc_err = 1'b1;
                endcase
            end else begin
                case (reg_idx)
                    CREG_CTRL: begin
                        // Clear has priority: a combined start+clear write never starts.
                        if (obi_we_i && obi_be_i[0]) begin
                            wr_clear = ch_sel & {NumChannels{obi_wdata_i[1]}};
                            wr_start = ch_sel & {NumChannels{obi_wdata_i[0] & ~obi_wdata_i[1]}};
                        end
                    end
                    CREG_STATUS: begin
                        if (!obi_we_i) begin
                            acc_rdata = {30'd0, done_q[ch_idx], busy_q[ch_idx]};
                        end else if (obi_be_i[0]) begin
                            wr_w1c = ch_sel & {NumChannels{obi_wdata_i[1]}};
                        end
                    end
                    CREG_BASE: begin
                        if (!obi_we_i)           acc_rdata = base_q[ch_idx];
                        else if (busy_q[ch_idx]) acc_err   = 1'b1;
                        else                     wr_base   = ch_sel;
                    end
                    CREG_WIDTH: begin
                        if (!obi_we_i)           acc_rdata = 32'(width_q[ch_idx]);
                        else if (busy_q[ch_idx]) acc_err   = 1'b1;
                        else                     wr_width  = ch_sel;
                    end
                    CREG_HEIGHT: begin
                        if (!obi_we_i)           acc_rdata = 32'(height_q[ch_idx]);
                        else if (busy_q[ch_idx]) acc_err   = 1'b1;
                        else                     wr_height = ch_sel;
                    end
                    default: acc_err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        start_d  = '0;
        clear_d  = '0;
        busy_d   = busy_q;
        done_d   = done_q;
        base_d   = base_q;
        width_d  = width_q;
        height_d = height_q;
        irq_en_d = wr_irq_en ? NumChannels'(be_merge(32'(irq_en_q), obi_wdata_i, obi_be_i))
                             : irq_en_q;
        for (int c = 0; c < NumChannels; c++) begin
            start_d[c] = wr_start[c] & ~busy_q[c];
            clear_d[c] = wr_clear[c];
            if (wr_clear[c]) begin
                busy_d[c] = 1'b0;
                done_d[c] = 1'b0;
            end else begin
                // A completion landing with a W1C wins, so software never loses a done event.
                if (wr_w1c[c]) done_d[c] = 1'b0;
                if (busy_q[c] && done_i[c]) begin
                    busy_d[c] = 1'b0;
                    done_d[c] = 1'b1;
                end else if (start_d[c]) begin
                    busy_d[c] = 1'b1;
                end
            end
            if (wr_base[c])   base_d[c]   = be_merge(base_q[c], obi_wdata_i, obi_be_i);
            if (wr_width[c])  width_d[c]  = DimWidth'(be_merge(32'(width_q[c]), obi_wdata_i, obi_be_i));
            if (wr_height[c]) height_d[c] = DimWidth'(be_merge(32'(height_q[c]), obi_wdata_i, obi_be_i));
        end
    end

    // NOTE: the per-channel register arrays are software-visible configuration, so they are
    // reset like ordinary flops instead of being treated as uninitialised storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            start_q  <= '0;
            clear_q  <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            for (int c = 0; c < NumChannels; c++) begin
                base_q[c]   <= '0;
                width_q[c]  <= '0;
                height_q[c] <= '0;
            end
        end else begin
            rvalid_q <= obi_req_i;
            err_q    <= acc_err;
            rdata_q  <= acc_rdata;
            start_q  <= start_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(done_q & irq_en_q);
            base_q   <= base_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign start_o      = start_q;
    assign clear_o      = clear_q;
    assign busy_o       = busy_q;
    assign irq_o        = irq_q;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch_out
        assign base_addr_o[32*c +: 32]           = base_q[c];
        assign width_o[DimWidth*c +: DimWidth]  = width_q[c];
        assign height_o[DimWidth*c +: DimWidth] = height_q[c];
    end

endmodule

// File: tb/tb_obi_accel_ctrl_regs.sv
// Directed bench for obi_accel_ctrl_regs: OBI responses checked through a scoreboard queue,
// side-band outputs (start/clear/busy/irq/config) checked inline after each step.
module tb_obi_accel_ctrl_regs;

    localparam int          N    = 2;
    localparam int          DW   = 16;
    localparam logic [31:0] BA   = 32'h2000_0000;
    localparam logic [31:0] CH0  = BA + 32'h000;
    localparam logic [31:0] CH1  = BA + 32'h020;
    localparam logic [31:0] GLB  = BA + 32'h040;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            obi_req_i = 1'b0;
    logic            obi_gnt_o;
    logic [31:0]     obi_addr_i = '0;
    logic            obi_we_i = 1'b0;
    logic [3:0]      obi_be_i = '0;
    logic [31:0]     obi_wdata_i = '0;
    logic            obi_rvalid_o;
    logic [31:0]     obi_rdata_o;
    logic            obi_err_o;
    logic [N-1:0]    start_o, clear_o, busy_o;
    logic [N-1:0]    done_i = '0;
    logic [N*32-1:0] base_addr_o;
    logic [N*DW-1:0] width_o, height_o;
    logic            irq_o;

    obi_accel_ctrl_regs #(.NumChannels(N), .BaseAddr(BA), .DimWidth(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .obi_req_i   (obi_req_i),
        .obi_gnt_o   (obi_gnt_o),
        .obi_addr_i  (obi_addr_i),
        .obi_we_i    (obi_we_i),
        .obi_be_i    (obi_be_i),
        .obi_wdata_i (obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o),
        .obi_rdata_o (obi_rdata_o),
        .obi_err_o   (obi_err_o),
        .start_o     (start_o),
        .clear_o     (clear_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .base_addr_o (base_addr_o),
        .width_o     (width_o),
        .height_o    (height_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk_i) begin : monitor
        resp_t e;
        string t;
        if (obi_rvalid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 64'(obi_rvalid_o), 64'd0);
            end else begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_err"}, 64'(obi_err_o), 64'(e.err));
                check({t, "_rdata"}, 64'(obi_rdata_o), 64'(e.rdata));
            end
        end
    end

    task automatic bus(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata);
        obi_req_i   = 1'b1;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wdata;
        sb_q.push_back('{err: exp_err, rdata: exp_rdata});
        tag_q.push_back(tag);
        #1 check({tag, "_gnt"}, 64'(obi_gnt_o), 64'd1);
        @(negedge clk_i);
        obi_req_i   = 1'b0;
        obi_we_i    = 1'b0;
        obi_be_i    = '0;
        obi_wdata_i = '0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err);
        bus(tag, 1'b1, addr, 4'hF, data, exp_err, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic exp_err,
                      input logic [31:0] exp_rdata);
        bus(tag, 1'b0, addr, 4'hF, 32'd0, exp_err, exp_rdata);
    endtask

    task automatic pulse_done(input logic [N-1:0] mask);
        done_i = mask;
        @(negedge clk_i);
        done_i = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_rvalid", 64'(obi_rvalid_o), 64'd0);
        check("rst_err",    64'(obi_err_o),    64'd0);
        check("rst_rdata",  64'(obi_rdata_o),  64'd0);
        check("rst_busy",   64'(busy_o),       64'd0);
        check("rst_irq",    64'(irq_o),        64'd0);
        check("rst_start",  64'(start_o),      64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Configuration write / read-back on channel 1
        wr("ch1_base_wr",   CH1 + 32'h08, 32'h8000_1000, 1'b0);
        wr("ch1_width_wr",  CH1 + 32'h0C, 32'd640,       1'b0);
        wr("ch1_height_wr", CH1 + 32'h10, 32'd480,       1'b0);
        rd("ch1_base_rd",   CH1 + 32'h08, 1'b0, 32'h8000_1000);
        rd("ch1_width_rd",  CH1 + 32'h0C, 1'b0, 32'd640);
        rd("ch1_height_rd", CH1 + 32'h10, 1'b0, 32'd480);
        check("ch1_base_out",   64'(base_addr_o[63:32]), 64'h8000_1000);
        check("ch1_width_out",  64'(width_o[31:16]),     64'd640);
        check("ch1_height_out", 64'(height_o[31:16]),    64'd480);

        // Start ch0, busy-protected config, done completion
        wr("ch0_start", CH0, 32'h1, 1'b0);
        check("ch0_start_pulse", 64'(start_o), 64'b01);
        check("ch0_busy_set",    64'(busy_o),  64'b01);
        wr("ch0_restart_busy", CH0, 32'h1, 1'b0);
        check("ch0_start_once", 64'(start_o), 64'b00);
        wr("ch0_width_busy", CH0 + 32'h0C, 32'h55, 1'b1);
        rd("ch0_width_keep", CH0 + 32'h0C, 1'b0, 32'd0);
        pulse_done(2'b01);
        check("ch0_busy_clr", 64'(busy_o), 64'b00);
        rd("ch0_status_done", CH0 + 32'h04, 1'b0, 32'h2);
        wr("ch0_w1c", CH0 + 32'h04, 32'h2, 1'b0);
        rd("ch0_status_clr", CH0 + 32'h04, 1'b0, 32'h0);

        // Interrupt path on channel 1
        wr("irq_en_wr", GLB, 32'h3, 1'b0);
        rd("irq_en_rd", GLB, 1'b0, 32'h3);
        wr("ch1_start", CH1, 32'h1, 1'b0);
        pulse_done(2'b10);
        check("irq_lag", 64'(irq_o), 64'd0);
        @(negedge clk_i);
        check("irq_set", 64'(irq_o), 64'd1);
        rd("irq_pend_rd", GLB + 32'h04, 1'b0, 32'h2);
        wr("ch1_w1c", CH1 + 32'h04, 32'h2, 1'b0);
        check("irq_hold", 64'(irq_o), 64'd1);
        @(negedge clk_i);
        check("irq_fall", 64'(irq_o), 64'd0);
        wr("ch1_start2", CH1, 32'h1, 1'b0);
        done_i = 2'b10;
        wr("ch1_w1c_vs_done", CH1 + 32'h04, 32'h2, 1'b0);
        done_i = '0;
        rd("ch1_done_wins", CH1 + 32'h04, 1'b0, 32'h2);
        wr("ch1_w1c2", CH1 + 32'h04, 32'h2, 1'b0);
        rd("ch1_status_clr", CH1 + 32'h04, 1'b0, 32'h0);

        // Clear behaviour
        wr("ch0_start_clear", CH0, 32'h3, 1'b0);
        check("clr_pulse",   64'(clear_o), 64'b01);
        check("clr_nostart", 64'(start_o), 64'b00);
        check("clr_idle",    64'(busy_o),  64'b00);
        wr("ch0_start3", CH0, 32'h1, 1'b0);
        check("ch0_busy3", 64'(busy_o), 64'b01);
        done_i = 2'b01;
        wr("ch0_clear_vs_done", CH0, 32'h2, 1'b0);
        done_i = '0;
        check("clr_done_pulse", 64'(clear_o), 64'b01);
        check("clr_done_busy",  64'(busy_o),  64'b00);
        rd("ch0_clear_wins", CH0 + 32'h04, 1'b0, 32'h0);

        // Error decode and byte enables
        rd("err_slot",      BA + 32'h060, 1'b1, 32'h0);
        rd("err_reg14",     CH0 + 32'h14, 1'b1, 32'h0);
        rd("err_unaligned", CH0 + 32'h09, 1'b1, 32'h0);
        wr("err_pend_wr",   GLB + 32'h04, 32'h1, 1'b1);
        rd("err_greg2",     GLB + 32'h08, 1'b1, 32'h0);
        rd("ctrl_reads0",   CH0, 1'b0, 32'h0);
        bus("be_lane1", 1'b1, CH0 + 32'h08, 4'b0010, 32'h0000_AB00, 1'b0, 32'h0);
        rd("be_lane1_rd", CH0 + 32'h08, 1'b0, 32'h0000_AB00);
        check("be_base_out", 64'(base_addr_o[31:0]), 64'h0000_AB00);
        bus("be_lane0", 1'b1, CH0 + 32'h08, 4'b0001, 32'hFFFF_FF12, 1'b0, 32'h0);
        rd("be_lane0_rd", CH0 + 32'h08, 1'b0, 32'h0000_AB12);
        wr("width_trunc", CH0 + 32'h0C, 32'hFFFF_1234, 1'b0);
        rd("width_trunc_rd", CH0 + 32'h0C, 1'b0, 32'h0000_1234);
        bus("ctrl_be0_off", 1'b1, CH0, 4'b1110, 32'h1, 1'b0, 32'h0);
        check("ctrl_be0_nostart", 64'(start_o), 64'b00);
        check("ctrl_be0_idle",    64'(busy_o),  64'b00);

        // Asynchronous reset with a busy channel and a response in flight
        wr("ch0_start4", CH0, 32'h1, 1'b0);
        obi_req_i  = 1'b1;
        obi_we_i   = 1'b0;
        obi_addr_i = CH1 + 32'h08;
        obi_be_i   = 4'hF;
        @(posedge clk_i);
        #1;
        check("pending_rvalid", 64'(obi_rvalid_o), 64'd1);
        rst_ni    = 1'b0;
        obi_req_i = 1'b0;
        #1;
        check("arst_rvalid", 64'(obi_rvalid_o), 64'd0);
        check("arst_rdata",  64'(obi_rdata_o),  64'd0);
        check("arst_busy",   64'(busy_o),       64'd0);
        check("arst_base",   64'(base_addr_o),  64'd0);
        check("arst_width",  64'(width_o),      64'd0);
        check("arst_height", 64'(height_o),     64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        check("post_rst_busy", 64'(busy_o), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
